// File: rtl/serial_word_feeder_if.sv
// Word-load handshake and serial stream bundle for serial_word_feeder.
// master = word producer, slave = the feeder itself.
interface serial_word_feeder_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] data_in;
    logic             load;
    logic             ready;
    logic             serial_out;
    logic             serial_valid;
    logic             busy;
    logic             done;

    modport master (
        output data_in,
        output load,
        input  ready,
        input  serial_out,
        input  serial_valid,
        input  busy,
        input  done
    );

    modport slave (
        input  data_in,
        input  load,
        output ready,
        output serial_out,
        output serial_valid,
        output busy,
        output done
    );
endinterface

// File: rtl/serial_word_feeder.sv
// Double-buffered parallel-to-serial feeder driving the detector's x input.
// Define SERIAL_WORD_FEEDER_LSB_FIRST_EN for LSB-first order (MSB-first otherwise).
module serial_word_feeder #(
    parameter int   WIDTH    = 8,
    parameter logic IDLE_BIT = 1'b0
) (
    input  logic                  clock,
    input  logic                  reset,
    serial_word_feeder_if.slave   bus
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_SHIFT = 1'b1;

    logic [0:0]       state_q,        state_d;
    logic [WIDTH-1:0] hold_reg_q,     hold_reg_d;
    logic             hold_full_q,    hold_full_d;
    logic [WIDTH-1:0] shift_reg_q,    shift_reg_d;
    logic [CW-1:0]    bit_cnt_q,      bit_cnt_d;
    logic             ready_q,        ready_d;
    logic             serial_out_q,   serial_out_d;
    logic             serial_valid_q, serial_valid_d;
    logic             busy_q,         busy_d;
    logic             done_q,         done_d;

    logic             accept;
    logic             last_bit;
    logic [WIDTH-1:0] shift_next;
    logic             out_bit_d;

    assign accept   = bus.load && ready_q;
    assign last_bit = (bit_cnt_q == LAST);

`ifdef SERIAL_WORD_FEEDER_LSB_FIRST_EN
    assign shift_next = {1'b0, shift_reg_q[WIDTH-1:1]};
    assign out_bit_d  = shift_reg_d[0];
`else
    assign shift_next = {shift_reg_q[WIDTH-2:0], 1'b0};
    assign out_bit_d  = shift_reg_d[WIDTH-1];
`endif

    // ready is low whenever hold is full, so accept and transfer never coincide
    always_comb begin
        state_d     = state_q;
        hold_reg_d  = hold_reg_q;
        hold_full_d = hold_full_q;
        shift_reg_d = shift_reg_q;
        bit_cnt_d   = bit_cnt_q;

        if (accept) begin
            hold_reg_d  = bus.data_in;
            hold_full_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (hold_full_q) begin
                    state_d     = S_SHIFT;
                    shift_reg_d = hold_reg_q;
                    bit_cnt_d   = '0;
                    hold_full_d = 1'b0;
                end
            end
            S_SHIFT: begin
                if (!last_bit) begin
                    shift_reg_d = shift_next;
                    bit_cnt_d   = bit_cnt_q + CW'(1);
                end else if (hold_full_q) begin
                    shift_reg_d = hold_reg_q;
                    bit_cnt_d   = '0;
                    hold_full_d = 1'b0;
                end else begin
                    state_d     = S_IDLE;
                    bit_cnt_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are registered from next-state so they line up with the shifter
    always_comb begin
        ready_d        = !hold_full_d;
        serial_valid_d = (state_d == S_SHIFT);
        serial_out_d   = serial_valid_d ? out_bit_d : IDLE_BIT;
        busy_d         = serial_valid_d || hold_full_d;
        done_d         = serial_valid_d && (bit_cnt_d == LAST);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= S_IDLE;
            hold_reg_q     <= '0;
            hold_full_q    <= 1'b0;
            shift_reg_q    <= '0;
            bit_cnt_q      <= '0;
            ready_q        <= 1'b1;
            serial_out_q   <= IDLE_BIT;
            serial_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            hold_reg_q     <= hold_reg_d;
            hold_full_q    <= hold_full_d;
            shift_reg_q    <= shift_reg_d;
            bit_cnt_q      <= bit_cnt_d;
            ready_q        <= ready_d;
            serial_out_q   <= serial_out_d;
            serial_valid_q <= serial_valid_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
        end
    end

    assign bus.ready        = ready_q;
    assign bus.serial_out   = serial_out_q;
    assign bus.serial_valid = serial_valid_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;

endmodule

// File: tb/tb_serial_word_feeder.sv
// Directed bench for serial_word_feeder (WIDTH=8, IDLE_BIT=0).
// Honours SERIAL_WORD_FEEDER_LSB_FIRST_EN for expected bit order.
module tb_serial_word_feeder;

    logic clock;
    logic reset;
    int   n_checks;
    int   n_fail;

    serial_word_feeder_if #(.WIDTH(8)) bus ();

    serial_word_feeder #(
        .WIDTH    (8),
        .IDLE_BIT (1'b0)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // i-th transmitted bit of a word
    function automatic logic bit_of(input logic [7:0] w, input int i);
`ifdef SERIAL_WORD_FEEDER_LSB_FIRST_EN
        return w[i];
`else
        return w[7-i];
`endif
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_idle(input string tag);
        check({tag, ".valid"}, 32'(bus.serial_valid), 32'd0);
        check({tag, ".out"},   32'(bus.serial_out),   32'd0);
        check({tag, ".busy"},  32'(bus.busy),         32'd0);
        check({tag, ".done"},  32'(bus.done),         32'd0);
        check({tag, ".ready"}, 32'(bus.ready),        32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] pair;
        n_checks     = 0;
        n_fail       = 0;
        reset        = 1'b1;
        bus.data_in  = '0;
        bus.load     = 1'b0;
        tick();
        tick();
        expect_idle("rst");
        reset = 1'b0;
        tick();
        expect_idle("post_rst");

        // single word 8'hB4
        bus.data_in = 8'hB4;
        bus.load    = 1'b1;
        tick();
        bus.load = 1'b0;
        check("single.e0.ready", 32'(bus.ready), 32'd0);
        check("single.e0.busy",  32'(bus.busy),  32'd1);
        check("single.e0.valid", 32'(bus.serial_valid), 32'd0);
        tick();
        check("single.e1.ready", 32'(bus.ready), 32'd1);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("single.bit%0d", i),
                  32'(bus.serial_out), 32'(bit_of(8'hB4, i)));
            check($sformatf("single.valid%0d", i),
                  32'(bus.serial_valid), 32'd1);
            check($sformatf("single.done%0d", i),
                  32'(bus.done), 32'(i == 7));
            tick();
        end
        expect_idle("single.end");

        // back-to-back FF then 00
        bus.data_in = 8'hFF;
        bus.load    = 1'b1;
        tick();
        bus.load = 1'b0;
        tick();
        pair = 16'hFF00;
        for (int k = 0; k < 16; k++) begin
            if (k == 0) begin
                bus.data_in = 8'h00;
                bus.load    = 1'b1;
            end else if (k == 1) begin
                bus.load = 1'b0;
            end
            check($sformatf("b2b.valid%0d", k),
                  32'(bus.serial_valid), 32'd1);
            check($sformatf("b2b.bit%0d", k),
                  32'(bus.serial_out), 32'(pair[15-k]));
            check($sformatf("b2b.ready%0d", k), 32'(bus.ready),
                  32'((k == 0) || (k >= 8)));
            check($sformatf("b2b.done%0d", k), 32'(bus.done),
                  32'((k == 7) || (k == 15)));
            tick();
        end
        expect_idle("b2b.end");

        // blocked load: AA offered while holding register is full
        bus.data_in = 8'h0F;
        bus.load    = 1'b1;
        tick();
        bus.load = 1'b0;
        tick();
        for (int k = 0; k < 16; k++) begin
            if (k == 0) begin
                bus.data_in = 8'hF0;
                bus.load    = 1'b1;
            end else if (k == 1) begin
                bus.data_in = 8'hAA;
                bus.load    = 1'b1;
            end else if (k == 3) begin
                bus.load = 1'b0;
            end
            if (k >= 1 && k <= 3)
                check($sformatf("blk.ready%0d", k), 32'(bus.ready), 32'd0);
            check($sformatf("blk.valid%0d", k),
                  32'(bus.serial_valid), 32'd1);
            check($sformatf("blk.bit%0d", k), 32'(bus.serial_out),
                  32'(k < 8 ? bit_of(8'h0F, k) : bit_of(8'hF0, k - 8)));
            tick();
        end
        for (int k = 0; k < 4; k++) begin
            expect_idle($sformatf("blk.idle%0d", k));
            tick();
        end

        // reset mid-word, then a fresh word
        bus.data_in = 8'hB4;
        bus.load    = 1'b1;
        tick();
        bus.load = 1'b0;
        tick();
        tick();
        tick();
        check("rmw.valid_before", 32'(bus.serial_valid), 32'd1);
        #3;
        reset = 1'b1;
        #1;
        expect_idle("rmw.async");
        tick();
        expect_idle("rmw.held");
        reset = 1'b0;
        tick();
        expect_idle("rmw.release");
        bus.data_in = 8'h80;
        bus.load    = 1'b1;
        tick();
        bus.load = 1'b0;
        check("rmw.e0.valid", 32'(bus.serial_valid), 32'd0);
        tick();
        for (int i = 0; i < 8; i++) begin
            check($sformatf("rmw.bit%0d", i),
                  32'(bus.serial_out), 32'(bit_of(8'h80, i)));
            check($sformatf("rmw.valid%0d", i),
                  32'(bus.serial_valid), 32'd1);
            tick();
        end
        expect_idle("rmw.end");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
